// File: rtl/recorder_pkg.sv
// Shared encodings for the track recorder: FSM states, key codes and the menu key map.
package recorder_pkg;

    localparam int SLOT_W = 4;

    typedef enum logic [3:0] {
        ST_MENU     = 4'd0,
        ST_PLAY_SEL = 4'd1,
        ST_PLAY     = 4'd2,
        ST_RECORD   = 4'd3,
        ST_DEL_SEL  = 4'd4,
        ST_VOLUME   = 4'd5,
        ST_FULL     = 4'd6
    } state_e;

    localparam logic [3:0] KEY_0       = 4'h0;
    localparam logic [3:0] KEY_PLAY    = 4'h1;
    localparam logic [3:0] KEY_REC     = 4'h2;
    localparam logic [3:0] KEY_DEL     = 4'h3;
    localparam logic [3:0] KEY_DEL_ALL = 4'h4;
    localparam logic [3:0] KEY_VOL     = 4'h5;
    localparam logic [3:0] KEY_VOL_UP  = 4'hA;
    localparam logic [3:0] KEY_VOL_DN  = 4'hB;

    function automatic state_e menu_target(input logic [3:0] key);
        case (key)
            KEY_PLAY: menu_target = ST_PLAY_SEL;
            KEY_REC:  menu_target = ST_RECORD;
            KEY_DEL:  menu_target = ST_DEL_SEL;
            KEY_VOL:  menu_target = ST_VOLUME;
            default:  menu_target = ST_MENU;
        endcase
    endfunction

endpackage

// File: rtl/track_table.sv
// Per-slot start/end/valid storage: one write port, clear-all, combinational lookup and lowest-free search.
module track_table
    import recorder_pkg::*;
#(
    parameter int NUM_TRACKS = 5,
    parameter int ADDR_W     = 26
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [SLOT_W-1:0]     wr_idx,
    input  logic [ADDR_W-1:0]     wr_start,
    input  logic [ADDR_W-1:0]     wr_end,
    input  logic                  wr_vld,
    input  logic                  clr_all,
    input  logic [SLOT_W-1:0]     rd_idx,
    output logic [ADDR_W-1:0]     rd_start,
    output logic [ADDR_W-1:0]     rd_end,
    output logic                  rd_valid,
    output logic [NUM_TRACKS-1:0] valid,
    output logic                  free_found,
    output logic [SLOT_W-1:0]     free_idx
);

    logic [NUM_TRACKS-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]     start_q [NUM_TRACKS];
    logic [ADDR_W-1:0]     start_d [NUM_TRACKS];
    logic [ADDR_W-1:0]     end_q   [NUM_TRACKS];
    logic [ADDR_W-1:0]     end_d   [NUM_TRACKS];

    always_comb begin
        valid_d = valid_q;
        start_d = start_q;
        end_d   = end_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_TRACKS; i++) begin
                if (wr_idx == SLOT_W'(i)) begin
                    valid_d[i] = wr_vld;
                    start_d[i] = wr_start;
                    end_d[i]   = wr_end;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Addresses are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge CLK) begin
        start_q <= start_d;
        end_q   <= end_d;
    end

    always_comb begin
        rd_start   = '0;
        rd_end     = '0;
        rd_valid   = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            if (rd_idx == SLOT_W'(i)) begin
                rd_start = start_q[i];
                rd_end   = end_q[i];
                rd_valid = valid_q[i];
            end
        end
        for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    assign valid = valid_q;

endmodule

// File: rtl/track_manager.sv
// Keypad-driven track recorder: records sample streams into memory slots, plays, deletes, sets volume.
module track_manager
    import recorder_pkg::*;
#(
    parameter int NUM_TRACKS = 5,
    parameter int ADDR_W     = 26,
    parameter int VOL_W      = 3,
    parameter int MEM_TOP    = 2**ADDR_W - 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  sample_tick,
    input  logic                  mem_ready,
    input  logic                  mem_ack,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wr_req,
    output logic                  mem_rd_req,
    output logic                  play_strobe,
    output logic [VOL_W-1:0]      volume,
    output logic [NUM_TRACKS-1:0] track_valid,
    output logic                  mem_full,
    output logic                  err_pulse,
    output logic [3:0]            state_out
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(MEM_TOP);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [VOL_W-1:0]  VOL_MAX  = '1;

    state_e              state_q, state_d;
    logic [VOL_W-1:0]    volume_q, volume_d;
    logic [ADDR_W-1:0]   next_free_q, next_free_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   play_end_q, play_end_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                wrote_q, wrote_d;
    logic                stop_q, stop_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic                tbl_we, tbl_vld, tbl_clr;
    logic [SLOT_W-1:0]   tbl_idx;
    logic [ADDR_W-1:0]   tbl_start, tbl_end;
    logic [ADDR_W-1:0]   lk_start, lk_end;
    logic                lk_valid, free_found;
    logic [SLOT_W-1:0]   free_idx, key_slot;
    logic                key_slot_ok, key0, tick_ok, wr_ack, rd_ack, rec_last;
    logic [ADDR_W-1:0]   rec_end;

    assign key_slot    = key_code - 4'd1;
    assign key_slot_ok = key_valid && (key_code != KEY_0) && (int'(key_code) <= NUM_TRACKS);
    assign key0        = key_valid && (key_code == KEY_0);
    // A tick is only honoured with the memory ready and nothing in flight; otherwise it is lost.
    assign tick_ok     = sample_tick && mem_ready && !wr_req_q && !rd_req_q;
    assign wr_ack      = wr_req_q && mem_ack;
    assign rd_ack      = rd_req_q && mem_ack;
    assign rec_last    = wr_ack && (addr_q == TOP_ADDR);
    assign rec_end     = wr_ack ? addr_q : (ptr_q - ONE);

    track_table #(
        .NUM_TRACKS(NUM_TRACKS),
        .ADDR_W    (ADDR_W)
    ) u_table (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (tbl_we),
        .wr_idx    (tbl_idx),
        .wr_start  (tbl_start),
        .wr_end    (tbl_end),
        .wr_vld    (tbl_vld),
        .clr_all   (tbl_clr),
        .rd_idx    (key_slot),
        .rd_start  (lk_start),
        .rd_end    (lk_end),
        .rd_valid  (lk_valid),
        .valid     (track_valid),
        .free_found(free_found),
        .free_idx  (free_idx)
    );

    always_comb begin
        state_d     = state_q;
        volume_d    = volume_q;
        next_free_d = next_free_q;
        ptr_d       = ptr_q;
        play_end_d  = play_end_q;
        addr_d      = addr_q;
        slot_d      = slot_q;
        wrote_d     = wrote_q;
        stop_d      = stop_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        full_d      = full_q;
        err_d       = 1'b0;
        tbl_we      = 1'b0;
        tbl_vld     = 1'b0;
        tbl_clr     = 1'b0;
        tbl_idx     = slot_q;
        tbl_start   = next_free_q;
        tbl_end     = rec_end;

        case (state_q)
            ST_MENU: begin
                if (key_valid) begin
                    if (key_code == KEY_DEL_ALL) begin
                        tbl_clr     = 1'b1;
                        next_free_d = '0;
                        full_d      = 1'b0;
                    end else if (menu_target(key_code) == ST_RECORD) begin
                        if (free_found && !full_q) begin
                            slot_d  = free_idx;
                            ptr_d   = next_free_q;
                            wrote_d = 1'b0;
                            stop_d  = 1'b0;
                            state_d = ST_RECORD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_FULL;
                        end
                    end else begin
                        state_d = menu_target(key_code);
                    end
                end
            end
            ST_PLAY_SEL: begin
                if (key0) begin
                    state_d = ST_MENU;
                end else if (key_slot_ok) begin
                    if (lk_valid) begin
                        ptr_d      = lk_start;
                        play_end_d = lk_end;
                        stop_d     = 1'b0;
                        state_d    = ST_PLAY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DEL_SEL: begin
                if (key0) begin
                    state_d = ST_MENU;
                end else if (key_slot_ok && lk_valid) begin
                    tbl_we    = 1'b1;
                    tbl_idx   = key_slot;
                    tbl_start = lk_start;
                    tbl_end   = lk_end;
                    // Only the most recently placed track can hand its space back.
                    if ((lk_end + ONE) == next_free_q) begin
                        next_free_d = lk_start;
                        full_d      = 1'b0;
                    end
                end
            end
            ST_RECORD: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    ptr_d    = ptr_q + ONE;
                    wrote_d  = 1'b1;
                end
                if (rec_last || ((key0 || stop_q) && (!wr_req_q || wr_ack))) begin
                    if (wr_ack || wrote_q) begin
                        tbl_we      = 1'b1;
                        tbl_vld     = 1'b1;
                        next_free_d = rec_end + ONE;
                    end
                    stop_d = 1'b0;
                    if (rec_last) begin
                        full_d  = 1'b1;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_MENU;
                    end
                end else if (key0) begin
                    stop_d = 1'b1;
                end else if (tick_ok && !stop_q) begin
                    wr_req_d = 1'b1;
                    addr_d   = ptr_q;
                end
            end
            ST_PLAY: begin
                if (rd_ack) begin
                    rd_req_d = 1'b0;
                    ptr_d    = ptr_q + ONE;
                end
                if ((rd_ack && addr_q == play_end_q) || ((key0 || stop_q) && (!rd_req_q || rd_ack))) begin
                    stop_d  = 1'b0;
                    state_d = ST_MENU;
                end else if (key0) begin
                    stop_d = 1'b1;
                end else if (tick_ok && !stop_q) begin
                    rd_req_d = 1'b1;
                    addr_d   = ptr_q;
                end
            end
            ST_VOLUME: begin
                if (key0) begin
                    state_d = ST_MENU;
                end else if (key_valid && key_code == KEY_VOL_UP && volume_q != VOL_MAX) begin
                    volume_d = volume_q + 1'b1;
                end else if (key_valid && key_code == KEY_VOL_DN && volume_q != '0) begin
                    volume_d = volume_q - 1'b1;
                end
            end
            ST_FULL: state_d = ST_MENU;
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_MENU;
            volume_q    <= '0;
            next_free_q <= '0;
            ptr_q       <= '0;
            play_end_q  <= '0;
            addr_q      <= '0;
            slot_q      <= '0;
            wrote_q     <= 1'b0;
            stop_q      <= 1'b0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            volume_q    <= volume_d;
            next_free_q <= next_free_d;
            ptr_q       <= ptr_d;
            play_end_q  <= play_end_d;
            addr_q      <= addr_d;
            slot_q      <= slot_d;
            wrote_q     <= wrote_d;
            stop_q      <= stop_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wr_req  = wr_req_q;
    assign mem_rd_req  = rd_req_q;
    assign play_strobe = rd_ack;
    assign volume      = volume_q;
    assign mem_full    = full_q;
    assign err_pulse   = err_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_track_manager.sv
// Directed bench for track_manager with a small memory (MEM_TOP=7) so the full condition is reachable.
module tb_track_manager;

    localparam int NT = 5;
    localparam int AW = 8;
    localparam int VW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          key_valid, sample_tick, mem_ready, mem_ack;
    logic [3:0]    key_code;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_req, mem_rd_req, play_strobe, mem_full, err_pulse;
    logic [VW-1:0] volume;
    logic [NT-1:0] track_valid;
    logic [3:0]    state_out;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int overlap = 0;

    track_manager #(
        .NUM_TRACKS(NT),
        .ADDR_W    (AW),
        .VOL_W     (VW),
        .MEM_TOP   (7)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .sample_tick(sample_tick),
        .mem_ready  (mem_ready),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_wr_req (mem_wr_req),
        .mem_rd_req (mem_rd_req),
        .play_strobe(play_strobe),
        .volume     (volume),
        .track_valid(track_valid),
        .mem_full   (mem_full),
        .err_pulse  (err_pulse),
        .state_out  (state_out)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (play_strobe) strobes++;
        if (mem_wr_req && mem_rd_req) overlap++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        cyc();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic ack(input logic is_rd, input string tag);
        mem_ack = 1'b1;
        #1;
        if (is_rd) check_val({tag, "_strobe"}, play_strobe, 1);
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic tick_ack(input logic is_rd, input logic [AW-1:0] a, input string tag);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check_val({tag, "_req"}, is_rd ? mem_rd_req : mem_wr_req, 1);
        check_val({tag, "_addr"}, mem_addr, a);
        ack(is_rd, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        sample_tick = 1'b0; mem_ready = 1'b1; mem_ack = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_state", state_out, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_valid", track_valid, 0);
        check_val("rst_vol", volume, 0);
        check_val("rst_full", mem_full, 0);
        check_val("rst_req", {mem_wr_req, mem_rd_req, play_strobe, err_pulse}, 0);
        RST = 1'b1;
        cyc();

        // Record 4 words into slot 0
        press(4'h2);
        check_val("rec_state", state_out, 3);
        for (int i = 0; i < 4; i++) tick_ack(1'b0, AW'(i), "rec");
        press(4'h0);
        check_val("rec_valid", track_valid, 5'b00001);
        check_val("rec_nf", dut.next_free_q, 4);
        check_val("rec_menu", state_out, 0);

        // Play slot 1, with a not-ready tick and a tick while a read is pending
        strobes = 0;
        press(4'h1);
        check_val("psel_state", state_out, 1);
        press(4'h1);
        check_val("play_state", state_out, 2);
        tick_ack(1'b1, 8'd0, "p0");
        mem_ready = 1'b0; sample_tick = 1'b1;
        cyc();
        mem_ready = 1'b1; sample_tick = 1'b0;
        check_val("p_notready", mem_rd_req, 0);
        sample_tick = 1'b1;
        cyc();
        check_val("p1_addr", mem_addr, 1);
        cyc();
        sample_tick = 1'b0;
        check_val("p1_busy_addr", mem_addr, 1);
        check_val("p1_busy_req", mem_rd_req, 1);
        ack(1'b1, "p1");
        cyc();
        check_val("p_noqueue", mem_rd_req, 0);
        tick_ack(1'b1, 8'd2, "p2");
        tick_ack(1'b1, 8'd3, "p3");
        check_val("play_strobes", strobes, 4);
        check_val("play_done", state_out, 0);

        // Zero-length record leaves everything untouched
        press(4'h2);
        press(4'h0);
        check_val("zero_valid", track_valid, 5'b00001);
        check_val("zero_nf", dut.next_free_q, 4);

        // Six-word track, stopping with a write still pending
        press(4'h4);
        check_val("delall_valid", track_valid, 0);
        press(4'h2);
        for (int i = 0; i < 5; i++) tick_ack(1'b0, AW'(i), "r6");
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check_val("r6_last_addr", mem_addr, 5);
        press(4'h0);
        check_val("r6_hold_req", mem_wr_req, 1);
        check_val("r6_hold_state", state_out, 3);
        ack(1'b0, "r6");
        check_val("r6_stop_state", state_out, 0);
        check_val("r6_valid", track_valid, 5'b00001);

        // Fill memory: writes 6 and 7, then a third tick is refused
        press(4'h2);
        tick_ack(1'b0, 8'd6, "f6");
        tick_ack(1'b0, 8'd7, "f7");
        check_val("full_state", state_out, 6);
        check_val("full_flag", mem_full, 1);
        check_val("full_valid", track_valid, 5'b00011);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check_val("full_menu", state_out, 0);
        check_val("full_nowrite", mem_wr_req, 0);
        press(4'h2);
        check_val("full_err", err_pulse, 1);
        check_val("full_err_state", state_out, 6);
        cyc();
        check_val("full_err_clr", err_pulse, 0);

        // Delete the last track (rewind), re-record, then delete a non-last track
        press(4'h3);
        check_val("dsel_state", state_out, 4);
        press(4'h2);
        check_val("del2_valid", track_valid, 5'b00001);
        check_val("del2_full", mem_full, 0);
        press(4'h0);
        press(4'h2);
        tick_ack(1'b0, 8'd6, "rw");
        press(4'h0);
        check_val("rw_valid", track_valid, 5'b00011);
        press(4'h3);
        press(4'h1);
        check_val("del1_valid", track_valid, 5'b00010);
        press(4'h0);
        press(4'h2);
        tick_ack(1'b0, 8'd7, "nr");
        check_val("nr_full_state", state_out, 6);
        cyc();

        // Selecting an empty slot for playback
        press(4'h1);
        press(4'h5);
        check_val("bad_sel_err", err_pulse, 1);
        check_val("bad_sel_state", state_out, 1);
        press(4'h0);

        // Volume saturation both ways
        press(4'h5);
        check_val("vol_state", state_out, 5);
        press(4'hA);
        check_val("vol_one", volume, 1);
        for (int i = 0; i < 8; i++) press(4'hA);
        check_val("vol_max", volume, 7);
        for (int i = 0; i < 9; i++) press(4'hB);
        check_val("vol_min", volume, 0);
        press(4'h0);
        check_val("vol_exit", state_out, 0);

        // Reset in the middle of a read; the late ack must be ignored
        press(4'h1);
        press(4'h1);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check_val("mid_req", mem_rd_req, 1);
        strobes = 0;
        RST = 1'b0;
        #1;
        check_val("mid_rst_req", mem_rd_req, 0);
        check_val("mid_rst_state", state_out, 0);
        check_val("mid_rst_addr", mem_addr, 0);
        check_val("mid_rst_valid", track_valid, 0);
        #1;
        RST = 1'b1;
        mem_ack = 1'b1;
        #1;
        check_val("late_ack_strobe", play_strobe, 0);
        cyc();
        mem_ack = 1'b0;
        cyc();
        check_val("late_ack_count", strobes, 0);
        check_val("no_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/track_manager.md
TRACK_MANAGER -- requirements
Module: track_manager

Interface
REQ-001 SHALL have parameter NUM_TRACKS, default 5, number of track slots (1..9).
REQ-002 SHALL have parameter ADDR_W, default 26, memory word address width.
REQ-003 SHALL have parameter VOL_W, default 3, volume register width.
REQ-004 SHALL have parameter MEM_TOP, default 2**ADDR_W-1, highest usable word address.
REQ-005 SHALL have port CLK, input, 1, single clock for all logic.
REQ-006 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port key_valid, input, 1, one-cycle pulse qualifying key_code.
REQ-008 SHALL have port key_code, input, 4, 0x0-0x9 digits, 0xA volume up, 0xB volume down.
REQ-009 SHALL have port sample_tick, input, 1, one-cycle pulse per audio sample period.
REQ-010 SHALL have port mem_ready, input, 1, memory interface calibrated and ready.
REQ-011 SHALL have port mem_ack, input, 1, one-cycle completion of the outstanding request.
REQ-012 SHALL have port mem_addr, output, ADDR_W, request address.
REQ-013 SHALL have port mem_wr_req, output, 1, write request, held until mem_ack.
REQ-014 SHALL have port mem_rd_req, output, 1, read request, held until mem_ack.
REQ-015 SHALL have port play_strobe, output, 1, pulse when a playback read completes.
REQ-016 SHALL have port volume, output, VOL_W, current volume.
REQ-017 SHALL have port track_valid, output, NUM_TRACKS, per-slot valid bits.
REQ-018 SHALL have ports mem_full (sticky), err_pulse (1 cycle) and state_out (4 bits, FSM state), all outputs.

Function
REQ-019 FSM states SHALL be MENU, PLAY_SEL, PLAY, RECORD, DEL_SEL, VOLUME and FULL, leaving reset in MENU.
REQ-020 In MENU the keys SHALL select: 1->PLAY_SEL, 2->RECORD, 3->DEL_SEL, 4->delete-all (stay in MENU), 5->VOLUME; all other keys are ignored.
REQ-021 In PLAY_SEL and DEL_SEL, key k in 1..NUM_TRACKS SHALL select slot k-1, key 0 SHALL return to MENU, and all other keys are ignored.
REQ-022 Selecting an invalid slot in PLAY_SEL SHALL pulse err_pulse and remain in PLAY_SEL.
REQ-023 Entering RECORD SHALL claim the lowest invalid slot, start = next_free; with no free slot, or with mem_full set, SHALL pulse err_pulse and go to FULL.
REQ-024 In RECORD, each sample_tick with mem_ready=1 and no request outstanding SHALL raise mem_wr_req at the write pointer; on mem_ack the pointer increments.
REQ-025 A sample_tick that arrives while a request is outstanding, or while mem_ready=0, SHALL be dropped with no queuing.
REQ-026 Record SHALL stop on key 0, or on the mem_ack of address MEM_TOP (which also sets mem_full and goes to FULL); then slot end = last written address, valid=1, next_free = end+1.
REQ-027 A record stopped with zero words written SHALL leave the slot invalid and next_free unchanged.
REQ-028 Key 0 pressed while a write is outstanding SHALL complete that write before stopping.
REQ-029 In PLAY, reads SHALL issue from start to end on sample_tick under the same rules, and each read mem_ack SHALL pulse play_strobe the same cycle.
REQ-030 After the end-address ack, PLAY SHALL return to MENU; key 0 SHALL abort after any outstanding read completes.
REQ-031 Deleting a slot SHALL clear its valid bit; if its end+1 equals next_free, next_free SHALL rewind to its start and mem_full SHALL clear.
REQ-032 Delete-all SHALL clear all valid bits, set next_free=0 and clear mem_full.
REQ-033 In VOLUME, 0xA and 0xB SHALL step volume by 1, saturating at 2**VOL_W-1 and 0 with no wrap; key 0 SHALL return to MENU.
REQ-034 FULL SHALL return to MENU on the next cycle.
REQ-035 mem_wr_req and mem_rd_req SHALL never both be 1.

Reset
REQ-036 On RST low, the FSM SHALL go to MENU and SHALL clear volume, next_free, all pointers, track_valid, mem_full, mem_wr_req, mem_rd_req, play_strobe and err_pulse, and SHALL set mem_addr=0.
REQ-037 Reset asserted mid-request SHALL drop the request immediately; a subsequent late mem_ack SHALL be ignored.

Structure
REQ-038 Package recorder_pkg SHALL hold the state encodings, the key-code constants and the menu-key mapping.
REQ-039 The start/end/valid storage SHALL be one sub-module, track_table, with a single write port and a combinational lookup, plus lowest-free-slot search.

Verification
REQ-040 Record: menu key 2, 4 ticks with immediate acks, key 0 -> writes to addresses 0..3, track_valid=00001, next_free=4.
REQ-041 Play: key 1, key 1 after REQ-040 -> reads 0..3, 4 play_strobe pulses, state MENU.
REQ-042 Full: MEM_TOP=7 with a 6-word track present, record 3 ticks -> writes 6,7, mem_full=1, FULL then MENU, and a third tick produces no write.
REQ-043 Rewind: delete slot 2 when it is last -> next_free returns to its start and mem_full=0; delete slot 1 when it is not last -> next_free unchanged.
REQ-044 Volume: key 0xA x9 from 0 -> volume=7; key 0xB x9 -> volume=0.
REQ-045 Reset: RST low while mem_rd_req=1 -> req=0 asynchronously, state MENU, late mem_ack produces no play_strobe.
